// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for a small accumulator CPU with a multi-cycle
// memory handshake.
//
// Each instruction walks FETCH -> DECODE -> EXEC -> FETCH. FETCH and the
// memory-class EXEC ops (ADD, SUB, LDA, STA) hold their request until
// mem_ready_i; the remaining ops finish EXEC in one cycle. A wait counter
// watches every stalled request. Once it has counted 2^TMO_W-1 stalled cycles,
// the next stalled cycle sends the FSM to ERR. A ready on that limit cycle
// still completes normally. ERR and HALT are held until reset.
//
// Optional feature: define CTRL_HALT_EN to decode the all-ones opcode as HLT
// (DECODE -> HALT, halt_o=1). Without it, all-ones is a NOP and halt_o is 0.
//
// Parameters
//   OPW    opcode width (>= 4)
//   TMO_W  memory-wait counter width; limit is 2^TMO_W-1 stalled cycles
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   op_i         opcode from the instruction register, sampled in DECODE
//   zf_i, cf_i   zero / carry flags for JZ / JC
//   mem_ready_i  memory handshake acknowledge
//   mem_rd_o     memory read request
//   wm_o         memory write request
//   ir_ld_o      instruction register load strobe
//   pc_inc_o     program counter increment strobe
//   jmp_o        PC load strobe (taken jump)
//   wr_o         accumulator write
//   wf_o         flag register write
//   alu_o        ALU mode, 0=add 1=sub
//   ldi_o        accumulator source = immediate
//   halt_o       core halted
//   err_o        memory timeout fault, sticky until reset
//   state_o      current state encoding (FETCH=0 DECODE=1 EXEC=2 HALT=3 ERR=4)

module multicycle_ctrl #(
  parameter int unsigned OPW   = 4,
  parameter int unsigned TMO_W = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [OPW-1:0] op_i,
  input  logic           zf_i,
  input  logic           cf_i,
  input  logic           mem_ready_i,
  output logic           mem_rd_o,
  output logic           wm_o,
  output logic           ir_ld_o,
  output logic           pc_inc_o,
  output logic           jmp_o,
  output logic           wr_o,
  output logic           wf_o,
  output logic           alu_o,
  output logic           ldi_o,
  output logic           halt_o,
  output logic           err_o,
  output logic [2:0]     state_o
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StHalt   = 3'd3,
    StErr    = 3'd4
  } state_e;

  localparam logic [OPW-1:0] OpAdd = OPW'(0);
  localparam logic [OPW-1:0] OpSub = OPW'(1);
  localparam logic [OPW-1:0] OpLda = OPW'(2);
  localparam logic [OPW-1:0] OpSta = OPW'(3);
  localparam logic [OPW-1:0] OpJmp = OPW'(4);
  localparam logic [OPW-1:0] OpJz  = OPW'(5);
  localparam logic [OPW-1:0] OpJc  = OPW'(6);
  localparam logic [OPW-1:0] OpLdi = OPW'(7);

  localparam logic [TMO_W-1:0] WaitLimit = '1;

  state_e             state_q, state_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [TMO_W-1:0]   wait_q, wait_d;
  logic               op_is_hlt;
  logic               mem_req;

`ifdef CTRL_HALT_EN
  assign op_is_hlt = (op_i == '1);
`else
  assign op_is_hlt = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = wait_q;
    mem_rd_o = 1'b0;
    wm_o     = 1'b0;
    ir_ld_o  = 1'b0;
    pc_inc_o = 1'b0;
    jmp_o    = 1'b0;
    wr_o     = 1'b0;
    wf_o     = 1'b0;
    alu_o    = 1'b0;
    ldi_o    = 1'b0;
    halt_o   = 1'b0;
    err_o    = 1'b0;
    state_o  = state_q;
    mem_req  = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          ir_ld_o  = 1'b1;
          pc_inc_o = 1'b1;
          state_d  = StDecode;
        end
      end

      StDecode: begin
        op_d    = op_i;
        state_d = op_is_hlt ? StHalt : StExec;
      end

      StExec: begin
        // Single-cycle ops fall through to FETCH; memory ops override below.
        state_d = StFetch;
        case (op_q)
          OpAdd: begin
            mem_rd_o = 1'b1;
            if (mem_ready_i) begin
              wr_o = 1'b1;
              wf_o = 1'b1;
            end else begin
              state_d = StExec;
            end
          end
          OpSub: begin
            mem_rd_o = 1'b1;
            if (mem_ready_i) begin
              wr_o  = 1'b1;
              wf_o  = 1'b1;
              alu_o = 1'b1;
            end else begin
              state_d = StExec;
            end
          end
          OpLda: begin
            mem_rd_o = 1'b1;
            if (mem_ready_i) begin
              wr_o = 1'b1;
            end else begin
              state_d = StExec;
            end
          end
          OpSta: begin
            wm_o = 1'b1;
            if (!mem_ready_i) begin
              state_d = StExec;
            end
          end
          OpJmp: jmp_o = 1'b1;
          OpJz:  jmp_o = zf_i;
          OpJc:  jmp_o = cf_i;
          OpLdi: begin
            wr_o  = 1'b1;
            ldi_o = 1'b1;
          end
          default: ;
        endcase
      end

      StHalt: begin
`ifdef CTRL_HALT_EN
        halt_o = 1'b1;
`endif
      end

      StErr: err_o = 1'b1;

      default: state_d = StFetch;
    endcase

    // Timeout: the counter holds the number of stalled cycles already seen,
    // so a stall while it sits at the limit is one stall too many.
    mem_req = mem_rd_o | wm_o;
    if (mem_req && !mem_ready_i) begin
      if (wait_q == WaitLimit) begin
        state_d = StErr;
      end else begin
        wait_d = wait_q + TMO_W'(1);
      end
    end
    if ((state_d != state_q) || (mem_req && mem_ready_i)) begin
      wait_d = '0;
    end

    // Reset cycle: everything quiet and FETCH reported, whatever the old state.
    if (rst_i) begin
      mem_rd_o = 1'b0;
      wm_o     = 1'b0;
      ir_ld_o  = 1'b0;
      pc_inc_o = 1'b0;
      jmp_o    = 1'b0;
      wr_o     = 1'b0;
      wf_o     = 1'b0;
      alu_o    = 1'b0;
      ldi_o    = 1'b0;
      halt_o   = 1'b0;
      err_o    = 1'b0;
      state_o  = 3'd0;
    end
  end

endmodule
